// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin sharing of the 7-seg display; define SEG_ARB_SRC_TAG_EN to show the source number in the leftmost digit
module seg_display_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned BLANK_CYCLES = 5_000_000,
    parameter int unsigned IDX_W        = $clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [32*NUM_SRC-1:0]  src_data,
    input  logic                   next_pulse,
    input  logic                   auto_en,
    input  logic                   freeze,
    output logic [31:0]            disp_data,
    output logic                   disp_en,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid
);
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] BLANK_LAST = BLANK_CYCLES > 0 ? 32'(BLANK_CYCLES - 1) : 32'd0;
    state_t             state_q, state_d;
    logic [31:0]        data_q, data_d, dwell_q, dwell_d, blank_q, blank_d;
    logic               en_q, en_d, gv_q, gv_d;
    logic [IDX_W-1:0]   idx_q, idx_d, ptr_q, ptr_d, win;
    logic [NUM_SRC-1:0] self_mask;
    logic [31:0]        cur_shown, win_shown;
    logic               found, others, trigger, go, to_idle;
`ifdef SEG_ARB_SRC_TAG_EN
    assign cur_shown = {4'(idx_q), src_data[32*idx_q +: 28]};
    assign win_shown = {4'(win), src_data[32*win +: 28]};
`else
    assign cur_shown = src_data[32*idx_q +: 32];
    assign win_shown = src_data[32*win +: 32];
`endif
    assign self_mask = NUM_SRC'(1) << idx_q;
    assign others    = |(req & ~self_mask);
    assign trigger   = next_pulse | (auto_en & ~freeze & (dwell_q == DWELL_LAST)) | ~req[idx_q];
    // Scan from the slot after the last grant so every requester gets a turn.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            if (!found && req[IDX_W'((int'(ptr_q) + k) % int'(NUM_SRC))]) begin
                win   = IDX_W'((int'(ptr_q) + k) % int'(NUM_SRC));
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dwell_d = dwell_q;
        blank_d = blank_q;
        en_d    = en_q;
        gv_d    = gv_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        go      = 1'b0;
        to_idle = 1'b0;
        case (state_q)
            IDLE: go = |req;
            SHOW: begin
                if (!freeze) data_d = cur_shown;
                if (auto_en && !freeze) dwell_d = dwell_q + 32'd1;
                if (trigger) begin
                    if (others) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d = BLANK;
                            en_d    = 1'b0;
                            gv_d    = 1'b0;
                            blank_d = '0;
                        end else go = 1'b1;
                    end else if (req[idx_q]) dwell_d = '0;
                    else to_idle = 1'b1;
                end
            end
            BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    go      = |req;
                    to_idle = ~|req;
                end else blank_d = blank_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d = SHOW;
            idx_d   = win;
            ptr_d   = win;
            data_d  = win_shown;
            dwell_d = '0;
            en_d    = 1'b1;
            gv_d    = 1'b1;
        end
        if (to_idle) begin
            state_d = IDLE;
            en_d    = 1'b0;
            gv_d    = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dwell_q <= '0;
            blank_q <= '0;
            en_q    <= 1'b0;
            gv_q    <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dwell_q <= dwell_d;
            blank_q <= blank_d;
            en_q    <= en_d;
            gv_q    <= gv_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end
    assign disp_data   = data_q;
    assign disp_en     = en_q;
    assign grant_idx   = idx_q;
    assign grant_valid = gv_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: scoreboard bench for seg_display_arbiter
module tb_seg_display_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } exp_t;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   src_data = '0;
    logic              next_pulse = 1'b0;
    logic              auto_en = 1'b0;
    logic              freeze = 1'b0;
    logic [31:0]       disp_data;
    logic              disp_en;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid;
    logic              gv_prev = 1'b0;
    exp_t              q[$];
    int                checks = 0;
    int                fails = 0;
    always #5 clk = ~clk;
    seg_display_arbiter #(.NUM_SRC(N), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
        .next_pulse(next_pulse), .auto_en(auto_en), .freeze(freeze),
        .disp_data(disp_data), .disp_en(disp_en), .grant_idx(grant_idx), .grant_valid(grant_valid)
    );
    function automatic logic [31:0] shown(input logic [IW-1:0] i, input logic [31:0] d);
`ifdef SEG_ARB_SRC_TAG_EN
        return {2'b00, i, d[27:0]};
`else
        return d;
`endif
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_src(input int i, input logic [31:0] v);
        src_data[32*i +: 32] = v;
    endtask
    task automatic expect_grant(input logic [IW-1:0] i, input logic [31:0] d);
        q.push_back('{i, shown(i, d)});
    endtask
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (grant_valid === lvl && n < 1000) begin
            n++;
            tick();
        end
    endtask
    task automatic pulse();
        next_pulse = 1'b1;
        tick();
        next_pulse = 1'b0;
    endtask
    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req = '0;
        next_pulse = 1'b0;
        auto_en = 1'b0;
        freeze = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask
    always @(negedge clk) begin
        exp_t e;
        check("en_eq_gv", 32'(disp_en), 32'(grant_valid));
        if (grant_valid && !gv_prev) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_grant: got idx %0d, required no grant", grant_idx);
            end else begin
                e = q.pop_front();
                check("grant_idx", 32'(grant_idx), 32'(e.idx));
                check("grant_data", disp_data, e.data);
            end
        end
        gv_prev = grant_valid;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        int drops;
        set_src(0, 32'h1111_1111);
        set_src(1, 32'h3333_3333);
        set_src(2, 32'h2222_2222);
        set_src(3, 32'h4444_4444);
        tick();
        tick();
        check("rst_data", disp_data, 32'h0);
        check("rst_en", 32'(disp_en), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_gv", 32'(grant_valid), 32'h0);
        rst_n = 1'b1;
        repeat (6) tick();
        check("idle_gv", 32'(grant_valid), 32'h0);
        check("idle_data", disp_data, 32'h0);
        check("idle_idx", 32'(grant_idx), 32'h0);
        auto_en = 1'b1;
        expect_grant(0, 32'h1111_1111);
        expect_grant(2, 32'h2222_2222);
        expect_grant(0, 32'h1111_1111);
        req = 4'b0101;
        tick();
        check("latency_gv", 32'(grant_valid), 32'h1);
        run_len(1'b1, n);
        check("rot_show0", n, 8);
        run_len(1'b0, n);
        check("rot_blank0", n, 2);
        check("rot_idx2", 32'(grant_idx), 32'h2);
        run_len(1'b1, n);
        check("rot_show2", n, 8);
        run_len(1'b0, n);
        check("rot_blank2", n, 2);
        check("rot_idx0", 32'(grant_idx), 32'h0);
        do_reset();
        expect_grant(0, 32'h1111_1111);
        expect_grant(1, 32'h3333_3333);
        expect_grant(3, 32'h4444_4444);
        expect_grant(0, 32'h1111_1111);
        req = 4'b1011;
        tick();
        check("man_gv0", 32'(grant_valid), 32'h1);
        tick();
        tick();
        pulse();
        check("man_blank_gv", 32'(grant_valid), 32'h0);
        run_len(1'b0, n);
        check("man_blank1", n, 2);
        repeat (20) tick();
        check("man_hold_idx", 32'(grant_idx), 32'h1);
        check("man_hold_gv", 32'(grant_valid), 32'h1);
        pulse();
        run_len(1'b0, n);
        check("man_blank3", n, 2);
        check("man_idx3", 32'(grant_idx), 32'h3);
        pulse();
        run_len(1'b0, n);
        check("man_idx0", 32'(grant_idx), 32'h0);
        freeze = 1'b1;
        auto_en = 1'b1;
        set_src(0, 32'h5555_5555);
        repeat (20) tick();
        check("frz_data", disp_data, shown(0, 32'h1111_1111));
        check("frz_idx", 32'(grant_idx), 32'h0);
        check("frz_gv", 32'(grant_valid), 32'h1);
        freeze = 1'b0;
        auto_en = 1'b0;
        tick();
        check("unfrz_data", disp_data, shown(0, 32'h5555_5555));
        expect_grant(1, 32'h3333_3333);
        req = 4'b1010;
        tick();
        check("drop_gv", 32'(grant_valid), 32'h0);
        run_len(1'b0, n);
        check("drop_blank", n, 2);
        check("drop_idx", 32'(grant_idx), 32'h1);
        expect_grant(1, 32'h3333_3333);
        next_pulse = 1'b1;
        tick();
        check("blank_ign_gv0", 32'(grant_valid), 32'h0);
        req = 4'b0010;
        tick();
        next_pulse = 1'b0;
        check("blank_ign_gv1", 32'(grant_valid), 32'h0);
        tick();
        check("rewin_gv", 32'(grant_valid), 32'h1);
        check("rewin_idx", 32'(grant_idx), 32'h1);
        req = 4'b0000;
        tick();
        check("none_gv", 32'(grant_valid), 32'h0);
        check("none_en", 32'(disp_en), 32'h0);
        repeat (5) tick();
        check("idle_stay", 32'(grant_valid), 32'h0);
        expect_grant(1, 32'h3333_3333);
        auto_en = 1'b1;
        req = 4'b0010;
        tick();
        check("stay_gv", 32'(grant_valid), 32'h1);
        drops = 0;
        repeat (20) begin
            tick();
            if (grant_valid !== 1'b1) drops++;
        end
        check("stay_drops", drops, 0);
        do_reset();
        auto_en = 1'b1;
        expect_grant(0, 32'h5555_5555);
        expect_grant(1, 32'h3333_3333);
        req = 4'b0111;
        tick();
        repeat (7) tick();
        pulse();
        check("sim_gv", 32'(grant_valid), 32'h0);
        run_len(1'b0, n);
        check("sim_blank", n, 2);
        check("sim_idx", 32'(grant_idx), 32'h1);
        tick();
        pulse();
        check("rb_pre_gv", 32'(grant_valid), 32'h0);
        rst_n = 1'b0;
        #2;
        check("rb_data", disp_data, 32'h0);
        check("rb_en", 32'(disp_en), 32'h0);
        check("rb_idx", 32'(grant_idx), 32'h0);
        check("rb_gv", 32'(grant_valid), 32'h0);
        tick();
        expect_grant(0, 32'h5555_5555);
        rst_n = 1'b1;
        tick();
        check("rb_regrant_idx", 32'(grant_idx), 32'h0);
        do_reset();
        set_src(2, 32'hABCD_1234);
        expect_grant(2, 32'hABCD_1234);
        req = 4'b0100;
        tick();
        check("tag_data", disp_data, shown(2, 32'hABCD_1234));
        check("tag_idx", 32'(grant_idx), 32'h2);
        tick();
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
